tetris_move_ctrl: RTL

Sequencer for falling-piece motion. Gathers left/right/down/rotate key requests and the gravity tick, arbitrates them one at a time, and proposes each candidate position/rotation to the board collision checker over a req/ack handshake. Commits accepted moves and locks the piece when a downward move fails. Sits between keyboard decode and the board/render logic.

---
 rtl/tetris_pkg.sv | 34 +++
 rtl/key_edge_repeat.sv | 50 +++++
 rtl/tetris_move_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared definitions for the falling-piece motion sequencer.
//   state_t : sequencer states (IDLE, PROPOSE, WAIT, COMMIT, LOCK)
//   move_t  : move kinds. The encoding doubles as the bit index of each
//             pending flag and as the arbitration priority (0 = highest).
//   TETRIS_* constants : default playfield size and spawn point.
package tetris_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PROPOSE = 3'd1,
    WAIT    = 3'd2,
    COMMIT  = 3'd3,
    LOCK    = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    MV_GRAV  = 3'd0,
    MV_ROT   = 3'd1,
    MV_LEFT  = 3'd2,
    MV_RIGHT = 3'd3,
    MV_DOWN  = 3'd4
  } move_t;

  localparam int TETRIS_BOARD_W = 10;
  localparam int TETRIS_BOARD_H = 20;
  localparam int TETRIS_SPAWN_X = 4;
  localparam int TETRIS_SPAWN_Y = 0;

  // Downward moves lock the piece when they fail; sideways/rotate are dropped.
  function automatic logic is_fall(input move_t m);
    return (m == MV_GRAV) || (m == MV_DOWN);
  endfunction

endpackage

// File: rtl/key_edge_repeat.sv
// Per-key request generator: one-cycle pulse on the rising edge of a key level,
// plus an optional autorepeat pulse every REPEAT_CYCLES cycles while held.
// Autorepeat exists only when MOVE_AUTOREPEAT_EN is defined and REPEAT_EN is 1.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   key    in  key level from keyboard decode
//   pulse  out request pulse (edge or repeat), combinational from key/key_q
module key_edge_repeat #(
  parameter int REPEAT_CYCLES = 8,
  parameter bit REPEAT_EN     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic pulse
);

`ifdef MOVE_AUTOREPEAT_EN
  localparam bit BUILD_RPT = 1'b1;
`else
  localparam bit BUILD_RPT = 1'b0;
`endif
  localparam bit RPT_ON = BUILD_RPT & REPEAT_EN;
  localparam int CW     = $clog2(REPEAT_CYCLES + 1);

  logic          key_q;
  logic [CW-1:0] cnt;
  logic          held;
  logic          rpt;

  assign held = key & key_q;
  assign rpt  = RPT_ON && held && (cnt == CW'(REPEAT_CYCLES - 1));
  assign pulse = (key & ~key_q) | rpt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= 1'b0;
      cnt   <= '0;
    end else begin
      key_q <= key;
      // Counts held cycles since the edge or last repeat; release restarts it.
      if (RPT_ON && held)
        cnt <= rpt ? '0 : cnt + CW'(1);
      else
        cnt <= '0;
    end
  end

endmodule

// File: rtl/tetris_move_ctrl.sv
// Falling-piece motion sequencer. Latches key/gravity requests as pending
// flags, serves one at a time (gravity > rotate > left > right > down),
// proposes the candidate to the collision checker over chk_req/chk_ack,
// commits accepted moves and locks/respawns the piece on a failed fall.
// Optional build macro: MOVE_AUTOREPEAT_EN (left/right autorepeat).
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   left, right, down, ro         key levels
//   grav_tick                     one-cycle gravity pulse
//   chk_req, cand_x/y/rot         candidate toward the checker (registered)
//   chk_ack, chk_ok               checker response, ok sampled with ack
//   pos_x, pos_y, rot             committed position/rotation
//   lock                          one-cycle pulse with the respawn position
//   busy                          high whenever the sequencer is not IDLE
module tetris_move_ctrl
  import tetris_pkg::*;
#(
  parameter int X_W           = 5,
  parameter int Y_W           = 5,
  parameter int ROT_W         = 2,
  parameter int BOARD_W       = TETRIS_BOARD_W,
  parameter int BOARD_H       = TETRIS_BOARD_H,
  parameter int SPAWN_X       = TETRIS_SPAWN_X,
  parameter int SPAWN_Y       = TETRIS_SPAWN_Y,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             left,
  input  logic             right,
  input  logic             down,
  input  logic             ro,
  input  logic             grav_tick,
  output logic             chk_req,
  output logic [X_W-1:0]   cand_x,
  output logic [Y_W-1:0]   cand_y,
  output logic [ROT_W-1:0] cand_rot,
  input  logic             chk_ack,
  input  logic             chk_ok,
  output logic [X_W-1:0]   pos_x,
  output logic [Y_W-1:0]   pos_y,
  output logic [ROT_W-1:0] rot,
  output logic             lock,
  output logic             busy
);

  logic left_evt, right_evt, down_evt, ro_evt;

  key_edge_repeat #(.REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1)) u_left (
    .clk(clk), .rst_n(rst_n), .key(left), .pulse(left_evt));
  key_edge_repeat #(.REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1)) u_right (
    .clk(clk), .rst_n(rst_n), .key(right), .pulse(right_evt));
  key_edge_repeat #(.REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b0)) u_down (
    .clk(clk), .rst_n(rst_n), .key(down), .pulse(down_evt));
  key_edge_repeat #(.REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b0)) u_ro (
    .clk(clk), .rst_n(rst_n), .key(ro), .pulse(ro_evt));

  state_t state, state_nx;
  move_t  mv, win;
  logic [4:0] pend, set, clr;
  logic             ld_cand, local_rej;
  logic [X_W-1:0]   nx_x;
  logic [Y_W-1:0]   nx_y;
  logic [ROT_W-1:0] nx_r;

  // Bit positions follow move_t.
  assign set = {down_evt, right_evt, left_evt, ro_evt, grav_tick};

  // Fixed-priority pick among pending flags.
  always_comb begin
    win = MV_DOWN;
    if      (pend[0]) win = MV_GRAV;
    else if (pend[1]) win = MV_ROT;
    else if (pend[2]) win = MV_LEFT;
    else if (pend[3]) win = MV_RIGHT;
  end

  // Candidate for the winning move and whether it can be refused without
  // asking the checker (playfield walls and floor).
  always_comb begin
    nx_x      = pos_x;
    nx_y      = pos_y;
    nx_r      = rot;
    local_rej = 1'b0;
    unique case (win)
      MV_GRAV, MV_DOWN: begin
        nx_y      = pos_y + Y_W'(1);
        local_rej = (pos_y == Y_W'(BOARD_H - 1));
      end
      MV_ROT:   nx_r = rot + ROT_W'(1);
      MV_LEFT: begin
        nx_x      = pos_x - X_W'(1);
        local_rej = (pos_x == '0);
      end
      MV_RIGHT: begin
        nx_x      = pos_x + X_W'(1);
        local_rej = (pos_x == X_W'(BOARD_W - 1));
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    clr      = '0;
    ld_cand  = 1'b0;
    unique case (state)
      IDLE: begin
        if (|pend) begin
          if (!local_rej) begin
            ld_cand  = 1'b1;
            state_nx = PROPOSE;
          end else if (is_fall(win)) begin
            state_nx = LOCK;
          end else begin
            clr = 5'b00001 << win;
          end
        end
      end
      PROPOSE: state_nx = WAIT;
      WAIT: begin
        if (chk_ack) begin
          if (chk_ok) begin
            state_nx = COMMIT;
          end else if (is_fall(mv)) begin
            state_nx = LOCK;
          end else begin
            clr      = 5'b00001 << mv;
            state_nx = IDLE;
          end
        end
      end
      COMMIT: begin
        clr      = 5'b00001 << mv;
        state_nx = IDLE;
      end
      LOCK: begin
        clr      = '1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // A new request in the same cycle as its clear wins, so nothing is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      mv       <= MV_GRAV;
      chk_req  <= 1'b0;
      cand_x   <= '0;
      cand_y   <= '0;
      cand_rot <= '0;
      pos_x    <= X_W'(SPAWN_X);
      pos_y    <= Y_W'(SPAWN_Y);
      rot      <= '0;
      lock     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      pend    <= (pend & ~clr) | set;
      chk_req <= (state_nx == PROPOSE) || (state_nx == WAIT);
      busy    <= (state_nx != IDLE);
      lock    <= (state == LOCK);
      if (ld_cand) begin
        mv       <= win;
        cand_x   <= nx_x;
        cand_y   <= nx_y;
        cand_rot <= nx_r;
      end
      if (state == COMMIT) begin
        pos_x <= cand_x;
        pos_y <= cand_y;
        rot   <= cand_rot;
      end else if (state == LOCK) begin
        pos_x <= X_W'(SPAWN_X);
        pos_y <= Y_W'(SPAWN_Y);
        rot   <= '0;
      end
    end
  end

endmodule
